// File: rtl/nibble_serial_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_serial_tx_if                                                  |
// | Handshake and serial-line bundle for the nibble link transmitter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface nibble_serial_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d;
    logic             valid;
    logic             ready;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output d,
        output valid,
        input  ready,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  d,
        input  valid,
        output ready,
        output tx,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_serial_tx                                                     |
// | Start / LSB-first data / optional parity / stop serialiser.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nibble_serial_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    nibble_serial_tx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] C_CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] C_BIT_LAST = BW'(WIDTH - 1);
    localparam logic          C_ODD      = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cyc_q,   cyc_d;
    logic [BW-1:0]    bit_q,   bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q,   par_d;
    logic             tx_q,    tx_d;
    logic             done_q,  done_d;

    logic             w_last;
    logic [WIDTH-1:0] w_shifted;

    assign w_last    = (cyc_q == C_CYC_LAST);
    assign w_shifted = shift_q >> 1;

    // tx_d always reflects the level of the state/bit being entered, so the
    // registered line switches on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (bus.valid) begin
                    shift_d = bus.d;
                    par_d   = (^bus.d) ^ C_ODD;
                    cyc_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_last) begin
                    cyc_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_DATA: begin
                if (w_last) begin
                    cyc_d   = '0;
                    shift_d = w_shifted;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == C_BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d = w_shifted[0];
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (w_last) begin
                    cyc_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_STOP: begin
                if (w_last) begin
                    cyc_d   = '0;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                cyc_d   = '0;
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.tx    = tx_q;
    assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nibble_serial_tx                                                  |
// | Directed bench: default, odd-parity and no-parity transmitters.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nibble_serial_tx;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    nibble_serial_tx_if #(.WIDTH(4)) if0 ();
    nibble_serial_tx_if #(.WIDTH(4)) if1 ();
    nibble_serial_tx_if #(.WIDTH(4)) if2 ();

    nibble_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0))
        u_even  (.clk(clk), .reset(reset), .bus(if0.slave));
    nibble_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1))
        u_odd   (.clk(clk), .reset(reset), .bus(if1.slave));
    nibble_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0))
        u_nopar (.clk(clk), .reset(reset), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic drv(input int k, input logic v, input logic [3:0] dd);
        case (k)
            0:       begin if0.valid = v; if0.d = dd; end
            1:       begin if1.valid = v; if1.d = dd; end
            default: begin if2.valid = v; if2.d = dd; end
        endcase
    endtask

    task automatic obs(input int k, output logic t, output logic b, output logic r, output logic dn);
        case (k)
            0:       begin t = if0.tx; b = if0.busy; r = if0.ready; dn = if0.done; end
            1:       begin t = if1.tx; b = if1.busy; r = if1.ready; dn = if1.done; end
            default: begin t = if2.tx; b = if2.busy; r = if2.ready; dn = if2.done; end
        endcase
    endtask

    // Each slot level repeated for the 4 clocks of one bit period.
    function automatic logic [31:0] expand(input logic [7:0] slots, input int ns);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < ns; i++)
            for (int c = 0; c < 4; c++)
                r[i*4+c] = slots[i];
        return r;
    endfunction

    task automatic capture(input int k, input int n, input int inj,
                           output logic [31:0] txv, output logic busyall);
        logic t, b, r, dn;
        txv     = '0;
        busyall = 1'b1;
        for (int j = 0; j < n; j++) begin
            obs(k, t, b, r, dn);
            txv[j]  = t;
            busyall = busyall & b;
            if (inj >= 0 && j == inj) begin
                chk("ignored_ready", {31'd0, r}, 32'd0);
                drv(k, 1'b1, 4'b0101);
            end else if (inj >= 0 && j == inj + 1) begin
                drv(k, 1'b0, 4'b0101);
            end
            if (j < n - 1) tick();
        end
    endtask

    task automatic finish_frame(input int k, input string tag);
        logic t, b, r, dn;
        tick();
        obs(k, t, b, r, dn);
        chk({tag, "_done"},  {31'd0, dn}, 32'd1);
        chk({tag, "_ready"}, {31'd0, r},  32'd1);
        chk({tag, "_idle"},  {30'd0, b, t}, 32'd1);
        tick();
        obs(k, t, b, r, dn);
        chk({tag, "_done_once"}, {31'd0, dn}, 32'd0);
    endtask

    task automatic send_check(input int k, input logic [3:0] dd, input logic [7:0] slots,
                              input int ns, input string tag);
        logic [31:0] txv;
        logic        ba;
        drv(k, 1'b1, dd);
        tick();
        drv(k, 1'b0, ~dd);
        capture(k, ns * 4, -1, txv, ba);
        chk({tag, "_tx"},   txv, expand(slots, ns));
        chk({tag, "_busy"}, {31'd0, ba}, 32'd1);
        finish_frame(k, tag);
    endtask

    initial begin
        logic [31:0] txv;
        logic        ba, t, b, r, dn, acc;
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        drv(0, 1'b0, 4'b0000);
        drv(1, 1'b0, 4'b0000);
        drv(2, 1'b0, 4'b0000);
        tick();
        tick();
        reset = 1'b0;

        obs(0, t, b, r, dn);
        chk("rst_tx",    {31'd0, t},  32'd1);
        chk("rst_ready", {31'd0, r},  32'd1);
        chk("rst_busy",  {31'd0, b},  32'd0);
        chk("rst_done",  {31'd0, dn}, 32'd0);
        acc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            obs(0, t, b, r, dn);
            acc = acc & t & ~b;
        end
        chk("idle_line_high", {31'd0, acc}, 32'd1);

        // start, 1,1,0,1, even parity 1, stop
        send_check(0, 4'b1011, 8'b0111_0110, 7, "frame_1011");
        send_check(0, 4'b0000, 8'b0100_0000, 7, "even_0000");
        send_check(1, 4'b0000, 8'b0110_0000, 7, "odd_0000");
        send_check(2, 4'b1111, 8'b0011_1110, 6, "nopar_1111");

        // Back-to-back: valid held, d switched only in the done cycle.
        drv(0, 1'b1, 4'b0000);
        tick();
        capture(0, 28, -1, txv, ba);
        chk("b2b_f1_tx",   txv, expand(8'b0100_0000, 7));
        chk("b2b_f1_busy", {31'd0, ba}, 32'd1);
        tick();
        obs(0, t, b, r, dn);
        chk("b2b_done", {29'd0, dn, r, t}, 32'd7);
        drv(0, 1'b1, 4'b1111);
        tick();
        obs(0, t, b, r, dn);
        chk("b2b_start2", {30'd0, b, t}, 32'd2);
        drv(0, 1'b0, 4'b0000);
        capture(0, 28, -1, txv, ba);
        chk("b2b_f2_tx",   txv, expand(8'b0101_1110, 7));
        chk("b2b_f2_busy", {31'd0, ba}, 32'd1);
        finish_frame(0, "b2b_f2");

        // valid pulse mid-frame must be ignored.
        drv(0, 1'b1, 4'b1100);
        tick();
        drv(0, 1'b0, 4'b0011);
        capture(0, 28, 10, txv, ba);
        chk("ignored_tx", txv, expand(8'b0101_1000, 7));
        finish_frame(0, "ignored");
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            obs(0, t, b, r, dn);
            acc = acc | b | ~t;
        end
        chk("ignored_no_extra", {31'd0, acc}, 32'd0);

        // Reset during DATA bit 2 (cycles 12..15 after accept).
        drv(0, 1'b1, 4'b1111);
        tick();
        drv(0, 1'b0, 4'b0000);
        for (int i = 0; i < 13; i++) tick();
        obs(0, t, b, r, dn);
        chk("midrst_pre_busy", {31'd0, b}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        obs(0, t, b, r, dn);
        chk("midrst_state", {28'd0, dn, b, r, t}, 32'h3);
        acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            obs(0, t, b, r, dn);
            acc = acc | dn | b | ~t;
        end
        chk("midrst_quiet", {31'd0, acc}, 32'd0);
        send_check(0, 4'b0011, 8'b0100_0110, 7, "after_rst_0011");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nibble_serial_tx.md
Name: nibble_serial_tx

Overview:
Parallel-to-serial transmitter that takes a WIDTH-bit word over a valid/ready handshake and shifts it out on a single line. Each frame is a start bit, the data bits LSB first, an optional parity bit, and a stop bit. It is the transmit end of the team's serial nibble link and sits between the register/flop datapath and the serial pin. Timing comes from an internal bit-period counter, so no separate baud clock is needed.

Parameters:
WIDTH, 4, number of data bits per frame (1..8).
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).
PARITY_EN, 1, 1 = parity bit inserted after the data bits; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity (bit = XOR of data); 1 = odd parity (bit = ~XOR of data).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
d  input  WIDTH  parallel word to send; sampled only on the accept edge.
valid  input  1  d is valid and a send is requested.
ready  output  1  transmitter can accept a word; high only in IDLE.
tx  output  1  serial line, registered; idles high.
busy  output  1  high from the first START cycle through the last STOP cycle.
done  output  1  one-cycle pulse in the first IDLE cycle after a complete frame.

Behaviour:
- Reset: sampled on the rising edge. After the reset edge: state=IDLE, tx=1, ready=1, busy=0, done=0, bit counter=0, cycle counter=0, shift register=0.
- Reset mid-frame: the next edge forces IDLE and tx=1. The word is discarded and done does not pulse.
- Accept: the edge where valid&&ready=1. d is latched into the shift register and the parity bit is computed from d and latched. The next state is START.
- valid while not ready is ignored. Changes on d after the accept edge have no effect on the current frame.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Every non-IDLE state lasts exactly CLKS_PER_BIT cycles. The cycle counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each state or bit change.
- START: tx=0.
- DATA: tx = shift register bit 0. At the end of each bit period the register shifts right and the bit counter increments. After bit index WIDTH-1 completes, go to PARITY, or to STOP when PARITY_EN=0.
- PARITY: tx = latched parity bit.
- STOP: tx=1. At the end of the period go to IDLE, and done=1 for that first IDLE cycle only.
- tx is registered, so the line changes on the edge that enters each state or bit.
- First START cycle: the cycle after the accept edge.
- Frame length: (2 + WIDTH + PARITY_EN) * CLKS_PER_BIT cycles. With defaults this is 28 cycles.
- ready = (state==IDLE), including the done cycle. A word can be accepted in the done cycle, giving back-to-back frames.
- Minimum line idle between frames: 1 cycle of tx=1 beyond the stop bit.
- busy = (state != IDLE).
- CLKS_PER_BIT=1: each bit lasts one cycle. There are no divide-by-zero or underflow paths.
- Counter widths: $clog2(CLKS_PER_BIT+1) for the cycle counter and $clog2(WIDTH+1) for the bit counter. Neither counter may wrap past its terminal value.

Test Plan:
- Reset behaviour: reset=1 for 2 cycles, then 0 -> tx=1, ready=1, busy=0, done=0. With valid=0, tx stays 1 for 20 cycles.
- Single frame (defaults): d=4'b1011, valid=1 for one cycle. Expected tx sequence, each level held 4 cycles: 0 | 1,1,0,1 | 1 (even parity of 1011) | 1. busy is high for 28 cycles and done pulses once at cycle 29 after the accept.
- Parity variants:
  - d=4'b0000 with PARITY_ODD=0 -> parity bit 0.
  - d=4'b0000 with PARITY_ODD=1 -> parity bit 1.
  - d=4'b1111, PARITY_EN=0 -> frame is 24 cycles with no parity slot.
- Back-to-back: hold valid=1 with d=4'b0000, then change d to 4'b1111 in the done cycle. The second frame's START begins exactly 1 cycle after the done cycle and carries 1111. The first frame is unaffected by the d change.
- Ignored input: pulse valid with d=4'b0101 mid-frame while busy=1 -> ready=0, the frame still carries the original word, and no extra frame is sent.
- Reset mid-frame: assert reset=1 during DATA bit 2 of d=4'b1111 -> the next edge gives tx=1, ready=1, busy=0, with no done pulse. A new d=4'b0011 sent afterwards transmits correctly.
